// File: rtl/quadrature_input_filter.sv
// Encoder front end: synchronises A/B/Z, filters glitches with a programmable
// persistence count, decodes quadrature into step/dir/err pulses, Avalon-MM status.
module quadrature_input_filter (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [31:0] avs_ctrl_writedata,
   output logic [31:0] avs_ctrl_readdata,
   input  logic [3:0]  avs_ctrl_byteenable,
   input  logic [2:0]  avs_ctrl_address,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic        avs_ctrl_waitrequest,
   input  logic        A,
   input  logic        B,
   input  logic        Z,
   output logic        A_o,
   output logic        B_o,
   output logic        Z_o,
   output logic        step_o,
   output logic        dir_o,
   output logic        err_o
);

   localparam logic [31:0] ID_VALUE = 32'hEA68_0004;

   logic            r_en;
   logic [7:0]      r_flt;
   logic [2:0]      r_s1;
   logic [2:0]      r_s2;
   logic [2:0]      r_f;
   logic [2:0][7:0] r_cnt;
   logic [1:0]      r_prev;
   logic            r_step;
   logic            r_dir;
   logic            r_err;
   logic [15:0]     r_errcnt;
   logic [31:0]     r_stepcnt;
   logic [31:0]     r_rdata;

   logic            w_ctrl_wr;
   logic            w_clr;
   logic [1:0]      w_cur;
   logic [1:0]      w_chg;
   logic            w_step;
   logic            w_err;
   logic            w_fwd;
   logic [31:0]     w_rdata;
   logic            w_unused;

   assign w_ctrl_wr = avs_ctrl_write && (avs_ctrl_address == 3'd1);
   assign w_clr     = w_ctrl_wr && avs_ctrl_byteenable[0] && avs_ctrl_writedata[1];
   assign w_unused  = ^{avs_ctrl_writedata[31:16], avs_ctrl_writedata[7:2], avs_ctrl_byteenable[3:2]};

   // Control register; CLR is not stored, it acts only on the write cycle
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_en  <= 1'b0;
         r_flt <= 8'd4;
      end else begin
         if (w_ctrl_wr && avs_ctrl_byteenable[0]) r_en  <= avs_ctrl_writedata[0];
         if (w_ctrl_wr && avs_ctrl_byteenable[1]) r_flt <= avs_ctrl_writedata[15:8];
      end
   end

   // Two-flop synchronisers for the raw pins, bit order {Z,B,A}
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_s1 <= 3'b000;
         r_s2 <= 3'b000;
      end else begin
         r_s1 <= {Z, B, A};
         r_s2 <= r_s1;
      end
   end

   // Persistence filter: s2 must disagree with f for FLT+1 edges before f follows
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_f   <= 3'b000;
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!r_en) begin
               r_f[i]   <= r_s2[i];
               r_cnt[i] <= 8'd0;
            end else if (r_s2[i] == r_f[i]) begin
               r_cnt[i] <= 8'd0;
            end else if (r_cnt[i] >= r_flt) begin
               r_f[i]   <= r_s2[i];
               r_cnt[i] <= 8'd0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign w_cur = {r_f[0], r_f[1]};
   assign w_chg = w_cur ^ r_prev;
   // For a single-bit change, forward exactly when new A differs from old B
   assign w_fwd = w_cur[1] ^ r_prev[0];

   // Classify the filtered AB change since the previous cycle
   always_comb begin
      w_step = 1'b0;
      w_err  = 1'b0;
      if (r_en) begin
         case (w_chg)
            2'b01, 2'b10: w_step = 1'b1;
            2'b11:        w_err  = 1'b1;
            default:      w_step = 1'b0;
         endcase
      end else begin
         w_step = 1'b0;
         w_err  = 1'b0;
      end
   end

   // Decoder outputs and event counters; CLR wins over a same-cycle increment
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_prev    <= 2'b00;
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
         r_errcnt  <= 16'd0;
         r_stepcnt <= 32'd0;
      end else begin
         r_prev <= w_cur;
         r_step <= w_step;
         r_err  <= w_err;
         if (w_step) r_dir <= w_fwd;
         if (w_clr) begin
            r_errcnt  <= 16'd0;
            r_stepcnt <= 32'd0;
         end else begin
            if (w_step) r_stepcnt <= r_stepcnt + 32'd1;
            if (w_err && (r_errcnt != 16'hFFFF)) r_errcnt <= r_errcnt + 16'd1;
         end
      end
   end

   // Register map read mux
   always_comb begin
      w_rdata = 32'd0;
      case (avs_ctrl_address)
         3'd0:    w_rdata = ID_VALUE;
         3'd1:    w_rdata = {16'd0, r_flt, 7'd0, r_en};
         3'd2:    w_rdata = {28'd0, r_dir, r_f[2], r_f[1], r_f[0]};
         3'd3:    w_rdata = {16'd0, r_errcnt};
         3'd4:    w_rdata = r_stepcnt;
         default: w_rdata = 32'd0;
      endcase
   end

   // Registered read data, updated only on a read strobe
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_rdata <= 32'd0;
      end else if (avs_ctrl_read) begin
         r_rdata <= w_rdata;
      end
   end

   assign avs_ctrl_readdata    = r_rdata;
   assign avs_ctrl_waitrequest = 1'b0;
   assign A_o                  = r_f[0];
   assign B_o                  = r_f[1];
   assign Z_o                  = r_f[2];
   assign step_o               = r_step;
   assign dir_o                = r_dir;
   assign err_o                = r_err;

endmodule

// File: tb/tb_quadrature_input_filter.sv
// Bench for quadrature_input_filter: directed test-plan checks plus randomized
// pin/bus traffic compared every cycle against a behavioural model.
module tb_quadrature_input_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  be;
   logic [2:0]  addr;
   logic        wr, rd, wait_s;
   logic        pa, pb, pz;
   logic        A_o, B_o, Z_o, step_o, dir_o, err_o;

   int n_checks = 0;
   int n_errors = 0;

   quadrature_input_filter dut (
      .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
      .avs_ctrl_writedata(wdata), .avs_ctrl_readdata(rdata),
      .avs_ctrl_byteenable(be), .avs_ctrl_address(addr),
      .avs_ctrl_write(wr), .avs_ctrl_read(rd), .avs_ctrl_waitrequest(wait_s),
      .A(pa), .B(pb), .Z(pz),
      .A_o(A_o), .B_o(B_o), .Z_o(Z_o),
      .step_o(step_o), .dir_o(dir_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // model state
   logic [2:0]  m_s1, m_s2, m_f;
   int          m_streak [3];
   logic [1:0]  m_prev;
   logic        m_dir, m_step, m_err, m_en, m_rd_valid;
   logic [7:0]  m_flt;
   int          m_errcnt;
   logic [31:0] m_stepcnt, m_rdata;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // position of an AB state along the forward cycle 00,10,11,01
   function automatic int quad_pos(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      m_s1 = 3'b0; m_s2 = 3'b0; m_f = 3'b0; m_prev = 2'b0;
      for (int i = 0; i < 3; i++) m_streak[i] = 0;
      m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0; m_en = 1'b0; m_flt = 8'd4;
      m_errcnt = 0; m_stepcnt = 32'd0; m_rdata = 32'd0; m_rd_valid = 1'b1;
   endtask

   task automatic model_edge();
      int d;
      m_rd_valid = rd;
      if (rd) begin
         case (addr)
            3'd0:    m_rdata = 32'hEA680004;
            3'd1:    m_rdata = {16'd0, m_flt, 8'd0} | {31'd0, m_en};
            3'd2:    m_rdata = {28'd0, m_dir, m_f[2], m_f[1], m_f[0]};
            3'd3:    m_rdata = 32'(m_errcnt);
            3'd4:    m_rdata = m_stepcnt;
            default: m_rdata = 32'd0;
         endcase
      end
      m_step = 1'b0;
      m_err  = 1'b0;
      if (m_en) begin
         d = (quad_pos(m_f[0], m_f[1]) - quad_pos(m_prev[1], m_prev[0]) + 4) % 4;
         if (d == 1 || d == 3) begin
            m_step = 1'b1;
            m_dir = (d == 1);
            m_stepcnt = m_stepcnt + 32'd1;
         end
         if (d == 2) begin
            m_err = 1'b1;
            if (m_errcnt < 65535) m_errcnt++;
         end
      end
      if (wr && addr == 3'd1 && be[0] && wdata[1]) begin
         m_errcnt = 0;
         m_stepcnt = 32'd0;
      end
      m_prev = {m_f[0], m_f[1]};
      for (int i = 0; i < 3; i++) begin
         if (!m_en || m_s2[i] == m_f[i]) begin
            if (!m_en) m_f[i] = m_s2[i];
            m_streak[i] = 0;
         end else begin
            m_streak[i]++;
            if (m_streak[i] >= int'(m_flt) + 1) begin
               m_f[i] = m_s2[i];
               m_streak[i] = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = {pz, pb, pa};
      if (wr && addr == 3'd1) begin
         if (be[0]) m_en  = wdata[0];
         if (be[1]) m_flt = wdata[15:8];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk);
      check_eq("outs", {26'd0, A_o, B_o, Z_o, dir_o, step_o, err_o},
               {26'd0, m_f[0], m_f[1], m_f[2], m_dir, m_step, m_err});
      if (m_rd_valid) check_eq("rdata", rdata, m_rdata);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      addr = a; rd = 1'b1;
      tick();
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic run(input int n, output int steps, output int errs);
      steps = 0; errs = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         steps += int'(step_o);
         errs  += int'(err_o);
      end
   endtask

   logic [31:0] rv;
   int          st, er, lat, tot_st, tot_er;
   logic        saw_b;

   initial begin
      rst = 1'b1; pa = 1'b0; pb = 1'b0; pz = 1'b0;
      wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 32'd0; be = 4'd0;
      model_reset();
      #12;
      check_eq("rst_outs", {26'd0, A_o, B_o, Z_o, dir_o, step_o, err_o}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("waitreq", {31'd0, wait_s}, 32'd0);
      @(negedge clk); rst = 1'b0;

      bus_read(3'd0, rv); check_eq("id", rv, 32'hEA680004);
      bus_read(3'd1, rv); check_eq("ctrl_rst", rv, 32'h00000400);
      bus_read(3'd3, rv); check_eq("errcnt_rst", rv, 32'd0);
      bus_read(3'd4, rv); check_eq("stepcnt_rst", rv, 32'd0);

      // filter latency with FLT=4
      bus_write(3'd1, 32'h00000401, 4'b0011);
      pa = 1'b1; lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (A_o && lat < 0) lat = k;
      end
      check_eq("a_latency", 32'(lat), 32'd7);

      // 4-cycle glitch on B must be swallowed
      saw_b = 1'b0; tot_st = 0;
      pb = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 4) pb = 1'b0;
         tick();
         saw_b |= B_o;
         tot_st += int'(step_o);
      end
      check_eq("glitch_b", {31'd0, saw_b}, 32'd0);
      check_eq("glitch_step", 32'(tot_st), 32'd0);

      // forward / reverse decode with FLT=0
      pa = 1'b0;
      run(12, st, er);
      bus_write(3'd1, 32'h00000003, 4'b0011);
      tot_st = 0;
      pa = 1'b1; run(4, st, er); tot_st += st;
      pb = 1'b1; run(4, st, er); tot_st += st;
      pa = 1'b0; run(4, st, er); tot_st += st;
      pb = 1'b0; run(4, st, er); tot_st += st;
      check_eq("fwd_steps", 32'(tot_st), 32'd4);
      check_eq("fwd_dir", {31'd0, dir_o}, 32'd1);
      bus_read(3'd4, rv); check_eq("stepcnt_fwd", rv, 32'd4);
      tot_st = 0;
      pb = 1'b1; run(4, st, er); tot_st += st;
      pa = 1'b1; run(4, st, er); tot_st += st;
      pb = 1'b0; run(4, st, er); tot_st += st;
      pa = 1'b0; run(4, st, er); tot_st += st;
      check_eq("rev_steps", 32'(tot_st), 32'd4);
      check_eq("rev_dir", {31'd0, dir_o}, 32'd0);
      bus_read(3'd4, rv); check_eq("stepcnt_rev", rv, 32'd8);

      // illegal transition 00 -> 11
      pa = 1'b1; pb = 1'b1;
      run(6, st, er);
      check_eq("ill_err", 32'(er), 32'd1);
      check_eq("ill_step", 32'(st), 32'd0);
      check_eq("ill_dir", {31'd0, dir_o}, 32'd0);
      bus_read(3'd3, rv); check_eq("errcnt_one", rv, 32'd1);

      // saturate the error counter
      for (int k = 0; k < 32'h10010; k++) begin
         pa = ~pa; pb = ~pb;
         tick();
      end
      pa = 1'b0; pb = 1'b0;
      run(6, st, er);
      bus_read(3'd3, rv); check_eq("errcnt_sat", rv, 32'h0000FFFF);

      // CLR on the same edge a step is decoded
      pa = 1'b1;
      run(3, st, er);
      bus_write(3'd1, 32'h00000403, 4'b0011);
      check_eq("clr_step", {31'd0, step_o}, 32'd1);
      bus_read(3'd4, rv); check_eq("clr_stepcnt", rv, 32'd0);
      bus_read(3'd3, rv); check_eq("clr_errcnt", rv, 32'd0);
      bus_read(3'd1, rv); check_eq("clr_ctrl", rv, 32'h00000401);

      // bypass: A_o follows in 3 edges, no pulses
      bus_write(3'd1, 32'h00000400, 4'b0011);
      run(8, st, er);
      pa = 1'b0; lat = -1; tot_st = 0; tot_er = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (!A_o && lat < 0) lat = k;
         tot_st += int'(step_o); tot_er += int'(err_o);
      end
      pa = 1'b1; pb = 1'b1;
      run(6, st, er); tot_st += st; tot_er += er;
      check_eq("byp_latency", 32'(lat), 32'd3);
      check_eq("byp_pulses", 32'(tot_st + tot_er), 32'd0);
      bus_read(3'd4, rv); check_eq("byp_stepcnt", rv, 32'd0);

      // byteenable: only byte 0 is written
      bus_write(3'd1, 32'h0000FF01, 4'b0001);
      bus_read(3'd1, rv); check_eq("be_ctrl", rv, 32'h00000401);

      // randomized traffic against the model
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 5) == 0) pa = ~pa;
         if ($urandom_range(0, 5) == 0) pb = ~pb;
         if ($urandom_range(0, 7) == 0) pz = ~pz;
         wr = ($urandom_range(0, 24) == 0);
         rd = ($urandom_range(0, 4) == 0);
         addr = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
         wdata = $urandom;
         wdata[15:8] = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
         be = 4'($urandom_range(0, 15));
         tick();
      end
      wr = 1'b0; rd = 1'b0;

      // asynchronous reset mid-operation
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("arst_outs", {26'd0, A_o, B_o, Z_o, dir_o, step_o, err_o}, 32'd0);
      check_eq("arst_rdata", rdata, 32'd0);
      model_reset();
      tick(); tick();
      rst = 1'b0;
      bus_read(3'd1, rv); check_eq("arst_ctrl", rv, 32'h00000400);
      bus_read(3'd4, rv); check_eq("arst_stepcnt", rv, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/quadrature_input_filter.md
# quadrature_input_filter

Front-end conditioner for incremental encoder signals. Synchronises raw A/B/Z pins into csi_MCLK_clk, removes glitches with a programmable digital filter, and decodes the cleaned quadrature into 1-cycle step/direction pulses. It also flags illegal transitions. The clean A/B/Z outputs drive the downstream position counter; status and counters are exposed on an Avalon-MM slave.

## Interface
- No parameters.
- csi_MCLK_clk  in  1  system clock
- rsi_MRST_reset  in  1  reset, asynchronous, active-high; clock csi_MCLK_clk
- avs_ctrl_writedata  in  32  write data
- avs_ctrl_readdata  out  32  registered read data
- avs_ctrl_byteenable  in  4  byte lanes for writes
- avs_ctrl_address  in  3  word address
- avs_ctrl_write  in  1  write strobe
- avs_ctrl_read  in  1  read strobe
- avs_ctrl_waitrequest  out  1  tied 0
- A, B, Z  in  1 each  raw asynchronous encoder pins
- A_o, B_o, Z_o  out  1 each  filtered signals to the position counter
- step_o  out  1  1-cycle pulse per valid quadrature edge
- dir_o  out  1  1 = forward (A leads B); held between steps
- err_o  out  1  1-cycle pulse per illegal transition

## Operation
- Register map (word address):
  - 0 ID, RO, 0xEA680004.
  - 1 CTRL, RW: bit0 EN (reset 0); bit1 CLR (write-1, self-clearing, reads 0); bits[15:8] FLT (reset 4). Other bits read 0.
  - 2 STATUS, RO: {28'b0, dir_o, Z_o, B_o, A_o}.
  - 3 ERRCNT, RO: {16'b0, errcnt}.
  - 4 STEPCNT, RO: 32-bit step count.
  - 5–7 read 0.
- Writes honour byteenable per byte. Writes to RO addresses are ignored.
- Synchroniser: two flops per pin (s1 to s2), reset 0.
- Filter, one instance per channel:
  - 8-bit counter cnt and output f (f = A_o/B_o/Z_o).
  - If s2 == f: cnt <= 0.
  - Else if cnt >= FLT: f <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Using >= makes lowering FLT mid-run safe. A new FLT value applies from the cycle after the write.
- EN=0 (bypass):
  - f <= s2 every cycle and cnt <= 0.
  - Decoder prev register still tracks f.
  - step_o and err_o are held 0; counters hold.
- Decoder (EN=1):
  - prev <= {A_o,B_o} every cycle.
  - Forward sequence {A,B}: 00→10→11→01→00. Reverse sequence is the opposite order.
  - Single-bit change: step_o=1, dir_o updated, STEPCNT+1 (wraps at 2^32).
  - Both bits changed in the same cycle: err_o=1, no step, dir_o unchanged, errcnt+1 saturating at 0xFFFF.
  - No change: nothing.
- CLR: zeroes errcnt and STEPCNT on the write cycle. It overrides a simultaneous increment.
- Z is filtered only; it is not decoded.

## Timing
- Reset values:
  - All outputs 0; readdata 0.
  - Synchronisers, filters, cnt, prev, errcnt and STEPCNT are 0.
  - EN=0, FLT=4.
- Pin-to-filtered latency: a pin change stable from before edge n appears on f after edge n+FLT+2, i.e. FLT+3 edges total. This requires the pin to be stable the whole time.
  - With FLT=0: 3 edges.
  - A pulse shorter than FLT+1 cycles at s2 never reaches f.
- step_o/err_o assert in the cycle after f changes, for exactly 1 cycle. dir_o updates together with step_o.
- Read latency: readdata is valid the cycle after avs_ctrl_read/address. It reflects register state at the read edge.
- Write effect: visible the cycle after avs_ctrl_write.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Pending filter counts are discarded.

## Test plan
- Reset/ID: assert reset, release, read addr0 → 0xEA680004. Read addr1 → 0x00000400. Read addr3/4 → 0. All outputs 0.
- Filter latency/glitch, EN=1, FLT=4:
  - Raise A and hold → A_o rises exactly 7 edges later.
  - A 4-cycle high glitch on B → B_o stays 0, no step.
- Forward/reverse decode, FLT=0: drive AB 00→10→11→01→00.
  - Required: 4 step pulses, dir_o=1, STEPCNT=4.
  - Then reverse 4 steps → dir_o=0, STEPCNT=8.
- Illegal transition: from AB=00, change A and B on the same cycle to 11.
  - Required: err_o pulses once, no step, ERRCNT=1, dir_o unchanged.
  - Force 0x10010 errors → ERRCNT saturates at 0xFFFF.
- CLR with simultaneous event: write CTRL=0x403 on the cycle a valid step is decoded → STEPCNT=0 and ERRCNT=0 afterwards, and CTRL reads 0x401.
- Bypass and byteenable:
  - EN=0, toggle A → A_o follows 3 edges later, no step/err pulses.
  - Write 0x0000FF01 with byteenable=4'b0001 → FLT stays 4, EN=1.
